pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 69, datapath payload width (ALU result 32 + store data 32 + destination register 5).
REQ-002 Parameter CTRL_W, default 7, control-bit vector width (Branch, MemRead, MemToReg, MemWrite, RegWrite, Jump, Zero).
REQ-003 Parameter CNT_W, default 16, performance counter width.
REQ-004 clk  input  1  rising-edge clock; one clock domain only.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream stage presents an entry.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 in_ctrl  input  CTRL_W  upstream control bits.
REQ-010 out_valid  output  1  downstream entry present.
REQ-011 out_ready  input  1  downstream consumes the entry this cycle.
REQ-012 out_data  output  DATA_W  head-entry payload.
REQ-013 out_ctrl  output  CTRL_W  head-entry control bits, forced to zero when out_valid=0.
REQ-014 flush  input  1  discard all held entries (branch/jump squash).
REQ-015 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
REQ-016 flush_cnt  output  CNT_W  flush cycles that discarded at least one entry.

Function
REQ-017 Accept = in_valid & in_ready; consume = out_valid & out_ready; all state changes on rising clk only.
REQ-018 Storage: main register (head) plus one skid register; state machine EMPTY, ONE, TWO.
REQ-019 in_ready SHALL be a registered output: 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-020 EMPTY: accept -> ONE, main<=input; otherwise stay EMPTY.
REQ-021 ONE: accept & consume -> ONE, main<=input; accept & !consume -> TWO, skid<=input; !accept & consume -> EMPTY; neither -> ONE, hold.
REQ-022 TWO: consume -> ONE, main<=skid; otherwise hold; no accept possible.
REQ-023 out_valid=1 in ONE and TWO; out_data/out_ctrl driven from main register only.
REQ-024 Latency: entry accepted at edge N is on out_* after edge N; sustained throughput one entry per cycle with out_ready held high.
REQ-025 Ordering: entries leave in acceptance order; no entry dropped or duplicated except by flush.
REQ-026 Flush: at the next edge state -> EMPTY regardless of in_valid/out_ready; an entry offered in the flush cycle is discarded; flush has priority over every transition.
REQ-027 Flush with state EMPTY SHALL NOT increment flush_cnt.
REQ-028 out_data contents while out_valid=0 are don't-care; out_ctrl SHALL be all-zero (bubble = no memory or register side effects).
REQ-029 Counters saturate at 2^CNT_W-1; no wrap.

Reset
REQ-030 rst_n low SHALL immediately force state EMPTY, in_ready=0, out_valid=0, out_ctrl=0, out_data=0, skid=0, stall_cnt=0, flush_cnt=0.
REQ-031 in_ready SHALL rise at the first clk edge after rst_n deasserts; reset mid-transfer discards all entries.

Configuration
REQ-032 Macro PIPE_STAGE_PERF_EN: defined -> stall_cnt and flush_cnt implemented per REQ-015/016/027/029.
REQ-033 Without PIPE_STAGE_PERF_EN: ports retained, stall_cnt and flush_cnt tied to constant zero, no counter flops; all other behaviour identical.

Verification
REQ-034 Streaming: out_ready=1, in_valid=1 for 10 cycles, in_data=1..10 -> out_data 1..10 on consecutive cycles, first one cycle after first accept, in_ready stays 1.
REQ-035 Backpressure: fill with 0xA then 0xB while out_ready=0 -> state TWO, in_ready=0, out_data=0xA held; release out_ready -> 0xA then 0xB, in_ready=1 one cycle after first consume.
REQ-036 Flush: state TWO, assert flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_ctrl=0, 0xC never appears, flush_cnt=1.
REQ-037 Reset mid-operation: rst_n low asynchronously while state ONE -> out_valid=0 and out_ctrl=0 before the next clk edge; in_ready=1 after first edge post-release.
REQ-038 Counters (macro defined, CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15; macro undefined -> stall_cnt=0 throughout.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
// slave = the stage register itself, master = the surrounding pipeline.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 7,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready, flush,
    input  in_ready, out_valid, out_data, out_ctrl, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready, flush,
    output in_ready, out_valid, out_data, out_ctrl, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register with flush and registered in_ready.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/flush counters.
module pipe_stage_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic              accept_s;
  logic              consume_s;
  logic              load_main_s;
  logic              skid_to_main_s;
  logic              load_skid_s;

  assign accept_s  = bus.in_valid & in_ready_r;
  assign consume_s = out_valid_r & bus.out_ready;

  // Next-state and datapath load selection; flush overrides every transition.
  always_comb begin
    state_nxt_s    = state_r;
    load_main_s    = 1'b0;
    skid_to_main_s = 1'b0;
    load_skid_s    = 1'b0;
    if (bus.flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_ONE;
            load_main_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && consume_s) begin
            state_nxt_s = ST_ONE;
            load_main_s = 1'b1;
          end else if (accept_s) begin
            state_nxt_s = ST_TWO;
            load_skid_s = 1'b1;
          end else if (consume_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a consume can move the state.
          if (consume_s) begin
            state_nxt_s    = ST_ONE;
            skid_to_main_s = 1'b1;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State plus registered handshake outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Head register; control is cleared whenever the stage goes empty so a bubble carries no side effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_r <= {DATA_W{1'b0}};
      main_ctrl_r <= {CTRL_W{1'b0}};
    end else begin
      if (load_main_s) begin
        main_data_r <= bus.in_data;
      end else if (skid_to_main_s) begin
        main_data_r <= skid_data_r;
      end else begin
        main_data_r <= main_data_r;
      end
      if (state_nxt_s == ST_EMPTY) begin
        main_ctrl_r <= {CTRL_W{1'b0}};
      end else if (load_main_s) begin
        main_ctrl_r <= bus.in_ctrl;
      end else if (skid_to_main_s) begin
        main_ctrl_r <= skid_ctrl_r;
      end else begin
        main_ctrl_r <= main_ctrl_r;
      end
    end
  end

  // Skid register catches the entry accepted while the head is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
    end else if (load_skid_s) begin
      skid_data_r <= bus.in_data;
      skid_ctrl_r <= bus.in_ctrl;
    end else begin
      skid_data_r <= skid_data_r;
      skid_ctrl_r <= skid_ctrl_r;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = main_data_r;
  assign bus.out_ctrl  = main_ctrl_r;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      return value;
    end else begin
      return value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Saturating counters: stalled head cycles, and flushes that discarded something.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (out_valid_r && !bus.out_ready) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (bus.flush && (state_r != ST_EMPTY)) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
